// File: rtl/hamming_window_mac.sv
// Two-stage streaming window multiplier with a run-time loadable, mirrored half coefficient table.
// Define HAMMING_ROUND_EN to round half-up before the final shift; undefined means a plain floor shift.
module hamming_window_mac #(
    parameter int unsigned FRAME_LEN = 160,
    parameter int unsigned IW        = 8,
    parameter int unsigned CAW       = 7,
    parameter int unsigned DW        = 16,
    parameter int unsigned CW        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [CAW-1:0]       cfg_addr,
    input  logic [CW-1:0]        cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 frame_err
);

    localparam int unsigned      HALF      = FRAME_LEN / 2;
    localparam logic [IW-1:0]    LAST_IDX  = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0]    HALF_IDX  = IW'(HALF);
    localparam logic [CAW:0]     HALF_ADDR = (CAW+1)'(HALF);
`ifdef HAMMING_ROUND_EN
    localparam logic signed [DW+CW-1:0] BIAS = (DW+CW)'(1) << (CW - 2);
`else
    localparam logic signed [DW+CW-1:0] BIAS = '0;
`endif

    logic [CW-1:0]           coef [HALF];
    logic [IW-1:0]           idx;
    logic [IW-1:0]           eff_idx;
    logic [IW-1:0]           mirror_idx;
    logic [CAW-1:0]          rd_addr;
    logic                    adv;
    logic                    accept;
    logic                    wr_ok;

    logic                    s1_valid;
    logic signed [DW-1:0]    s1_data;
    logic signed [CW-1:0]    s1_coef;
    logic                    s1_last;

    logic signed [DW+CW-1:0] prod;
    logic signed [DW+CW-1:0] biased;
    logic signed [DW-1:0]    windowed;

    always_comb begin
        adv        = !out_valid || out_ready;
        in_ready   = !s1_valid || adv;
        accept     = in_valid && in_ready;
        eff_idx    = in_sof ? '0 : idx;
        mirror_idx = LAST_IDX - eff_idx;
        rd_addr    = (eff_idx < HALF_IDX) ? CAW'(eff_idx) : CAW'(mirror_idx);
        wr_ok      = cfg_we && ({1'b0, cfg_addr} < HALF_ADDR);
    end

    always_comb begin
        prod     = s1_data * s1_coef;
        biased   = prod + BIAS;
        windowed = DW'(biased >>> (CW - 1));
    end

    // The S1 read samples the table before this edge's write lands, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < HALF; i++) coef[i] <= '0;
        end else if (wr_ok) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

    // S1 refills whenever it is empty or draining, even if the output stage is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_coef  <= '0;
            s1_last  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_coef <= coef[rd_addr];
                s1_last <= (eff_idx == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= windowed;
                out_last <= s1_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && in_sof && (idx != '0);
            if (accept) idx <= (eff_idx == LAST_IDX) ? '0 : eff_idx + 1'b1;
        end
    end

endmodule
